descrambler_sync: RTL and testbench

//  Receive-side counterpart of the team's 12-bit additive scrambler (x^12+x^9+x^2 taps, seed 12'h14D).
//  - Hunts for an unscrambled frame-sync word in the serial stream.
//  - Reseeds its LFSR at each frame start and descrambles PAYLOAD_LEN bits.
//  - Checks the sync word between frames; drops lock after MISS_MAX consecutive misses.
//  - Sits between the serial line deserialiser and the payload consumer.

---
 rtl/descrambler_sync.sv | 133 +++++++++++++
 tb/tb_descrambler_sync.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/descrambler_sync.sv
// Frame-synchronous descrambler: hunts an unscrambled sync word, then descrambles PAYLOAD_LEN bits per frame.
// Latency: one cycle from an accepted data_i bit to data_o/valid_o.
// No backpressure: valid_i low freezes all state; output is a one-cycle pulse per payload bit.
module descrambler_sync #(
    parameter int                  SYNC_LEN    = 16,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 16'hF628,
    parameter int                  PAYLOAD_LEN = 256,
    parameter int                  MISS_MAX    = 3,
    parameter logic [11:0]         SEED        = 12'h14D
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic data_i,
    input  logic valid_i,
    output logic data_o,
    output logic valid_o,
    output logic sof_o,
    output logic locked_o,
    output logic sync_err_o
);

    localparam int CNT_MAX = (PAYLOAD_LEN > SYNC_LEN) ? PAYLOAD_LEN : SYNC_LEN;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int MW      = $clog2(MISS_MAX + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [MW-1:0]       miss, miss_nxt, miss_inc;
    logic [11:0]         lfsr, lfsr_nxt;
    logic [SYNC_LEN-1:0] sr, sr_nxt, sr_shift;
    logic                locked_nxt, data_nxt, valid_nxt, sof_nxt, err_nxt;

    assign sr_shift = {sr[SYNC_LEN-2:0], data_i};
    assign miss_inc = miss + MW'(1);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        miss_nxt   = miss;
        lfsr_nxt   = lfsr;
        sr_nxt     = sr;
        locked_nxt = locked_o;
        data_nxt   = 1'b0;
        valid_nxt  = 1'b0;
        sof_nxt    = 1'b0;
        err_nxt    = 1'b0;
        if (valid_i) begin
            case (state)
                HUNT: begin
                    sr_nxt = sr_shift;
                    if (sr_shift == SYNC_WORD) begin
                        state_nxt  = PAYLOAD;
                        lfsr_nxt   = SEED;
                        cnt_nxt    = '0;
                        locked_nxt = 1'b1;
                        miss_nxt   = '0;
                    end
                end
                PAYLOAD: begin
                    // Keystream bit is taken before the shift register advances.
                    data_nxt  = data_i ^ lfsr[11];
                    valid_nxt = 1'b1;
                    sof_nxt   = (cnt == '0);
                    lfsr_nxt  = {lfsr[10:0], lfsr[11] ^ lfsr[8] ^ lfsr[1]};
                    if (cnt == CW'(PAYLOAD_LEN - 1)) begin
                        state_nxt = CHECK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                CHECK: begin
                    sr_nxt = sr_shift;
                    if (cnt == CW'(SYNC_LEN - 1)) begin
                        cnt_nxt  = '0;
                        lfsr_nxt = SEED;
                        if (sr_shift == SYNC_WORD) begin
                            miss_nxt  = '0;
                            state_nxt = PAYLOAD;
                        end else begin
                            err_nxt  = 1'b1;
                            miss_nxt = miss_inc;
                            if (miss_inc == MW'(MISS_MAX)) begin
                                state_nxt  = HUNT;
                                locked_nxt = 1'b0;
                                sr_nxt     = '0;
                            end else begin
                                // Flywheel: trust frame timing despite the bad sync.
                                state_nxt = PAYLOAD;
                            end
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= HUNT;
            cnt        <= '0;
            miss       <= '0;
            lfsr       <= SEED;
            sr         <= '0;
            locked_o   <= 1'b0;
            data_o     <= 1'b0;
            valid_o    <= 1'b0;
            sof_o      <= 1'b0;
            sync_err_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            miss       <= miss_nxt;
            lfsr       <= lfsr_nxt;
            sr         <= sr_nxt;
            locked_o   <= locked_nxt;
            data_o     <= data_nxt;
            valid_o    <= valid_nxt;
            sof_o      <= sof_nxt;
            sync_err_o <= err_nxt;
        end
    end

endmodule

// File: tb/tb_descrambler_sync.sv
// Bench for descrambler_sync: frames from a reference scrambler, outputs checked through an expected-bit queue.
module tb_descrambler_sync;

    localparam int          PAYLOAD_LEN = 256;
    localparam logic [15:0] SYNC_WORD   = 16'hF628;
    localparam logic [15:0] BAD_SYNC    = 16'hF629;
    localparam logic [11:0] SEED        = 12'h14D;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    logic data_i = 1'b0;
    logic valid_i = 1'b0;
    logic data_o, valid_o, sof_o, locked_o, sync_err_o;

    descrambler_sync dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .sof_o      (sof_o),
        .locked_o   (locked_o),
        .sync_err_o (sync_err_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks   = 0;
    int          failures = 0;
    int          n_valid  = 0;
    int          n_sof    = 0;
    int          n_err    = 0;
    logic [1:0]  exp_q[$];       // {expected data_o, expected sof_o}
    logic [1:0]  exp_e;
    logic [11:0] m_lfsr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every payload bit the DUT presents is matched against the queue head.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            check("sof_implies_valid", {31'd0, sof_o & ~valid_o}, 32'd0);
            if (valid_o) begin
                n_valid++;
                if (sof_o) n_sof++;
                check("expected_bit_available", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    exp_e = exp_q.pop_front();
                    check("data_o", {31'd0, data_o}, {31'd0, exp_e[1]});
                    check("sof_o", {31'd0, sof_o}, {31'd0, exp_e[0]});
                end
            end
            if (sync_err_o) n_err++;
        end
    end

    task automatic drive(input logic b, input logic v);
        @(negedge clk_i);
        data_i  = b;
        valid_i = v;
    endtask

    task automatic send_bit(input logic b, input bit gaps);
        if (gaps) begin
            while ($urandom_range(0, 9) < 3) drive(1'($urandom_range(0, 1)), 1'b0);
        end
        drive(b, 1'b1);
    endtask

    task automatic send_sync(input logic [15:0] w, input bit gaps);
        for (int i = 15; i >= 0; i--) send_bit(w[i], gaps);
    endtask

    task automatic model_step();
        m_lfsr = {m_lfsr[10:0], m_lfsr[11] ^ m_lfsr[8] ^ m_lfsr[1]};
    endtask

    // Reference scrambler: random payload, line bit = payload ^ keystream.
    task automatic send_payload(input int n, input bit gaps, input bit first);
        logic p;
        for (int i = 0; i < n; i++) begin
            p = 1'($urandom_range(0, 1));
            exp_q.push_back({p, first && (i == 0)});
            send_bit(p ^ m_lfsr[11], gaps);
            model_step();
        end
    endtask

    task automatic frame(input logic [15:0] w, input bit gaps);
        send_sync(w, gaps);
        m_lfsr = SEED;
        send_payload(PAYLOAD_LEN, gaps, 1'b1);
    endtask

    task automatic settle();
        drive(1'b0, 1'b0);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] ks12;
        int s0, e0, v0;

        // 1: reset held with random inputs
        rstn_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            data_i  = 1'($urandom_range(0, 1));
            valid_i = 1'($urandom_range(0, 1));
            #1;
            check("reset_outputs", {27'd0, data_o, valid_o, sof_o, locked_o, sync_err_o}, 32'd0);
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        rstn_i  = 1'b1;

        // 2: sync then 12 zeros -> seed keystream, hand-computed
        ks12 = 12'b0001_0100_1101;
        send_sync(SYNC_WORD, 1'b0);
        m_lfsr = SEED;
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({ks12[11-i], i == 0});
            drive(1'b0, 1'b1);
            model_step();
        end
        send_payload(PAYLOAD_LEN - 12, 1'b0, 1'b0);
        settle();
        check("t2_locked", {31'd0, locked_o}, 32'd1);
        check("t2_sof_count", n_sof, 1);

        // 3: three clean frames
        s0 = n_sof;
        e0 = n_err;
        for (int f = 0; f < 3; f++) frame(SYNC_WORD, 1'b0);
        settle();
        check("t3_sof_count", n_sof - s0, 3);
        check("t3_sync_err_count", n_err - e0, 0);
        check("t3_queue_drained", exp_q.size(), 0);
        check("t3_locked", {31'd0, locked_o}, 32'd1);

        // 4: frame with random valid_i gaps
        v0 = n_valid;
        frame(SYNC_WORD, 1'b1);
        settle();
        check("t4_valid_count", n_valid - v0, PAYLOAD_LEN);
        check("t4_queue_drained", exp_q.size(), 0);

        // 5: three corrupted syncs, flywheel then loss of lock and relock
        e0 = n_err;
        frame(BAD_SYNC, 1'b0);
        settle();
        check("t5_err_after_1", n_err - e0, 1);
        check("t5_locked_after_1", {31'd0, locked_o}, 32'd1);
        frame(BAD_SYNC, 1'b0);
        settle();
        check("t5_err_after_2", n_err - e0, 2);
        check("t5_locked_after_2", {31'd0, locked_o}, 32'd1);
        send_sync(BAD_SYNC, 1'b0);
        settle();
        check("t5_err_after_3", n_err - e0, 3);
        check("t5_locked_after_3", {31'd0, locked_o}, 32'd0);
        v0 = n_valid;
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1);
        settle();
        check("t5_no_output_in_hunt", n_valid - v0, 0);
        s0 = n_sof;
        frame(SYNC_WORD, 1'b0);
        settle();
        check("t5_relocked", {31'd0, locked_o}, 32'd1);
        check("t5_relock_sof", n_sof - s0, 1);
        check("t5_err_total", n_err - e0, 3);

        // 6: reset at payload bit 100, then a fresh frame
        send_sync(SYNC_WORD, 1'b0);
        m_lfsr = SEED;
        send_payload(100, 1'b0, 1'b1);
        @(negedge clk_i);
        valid_i = 1'b0;
        #2;
        check("t6_valid_before_reset", {31'd0, valid_o}, 32'd1);
        rstn_i = 1'b0;
        #1;
        check("t6_async_drop", {28'd0, data_o, valid_o, sof_o, locked_o}, 32'd0);
        check("t6_queue_drained", exp_q.size(), 0);
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        s0 = n_sof;
        frame(SYNC_WORD, 1'b0);
        settle();
        check("t6_relocked", {31'd0, locked_o}, 32'd1);
        check("t6_sof_count", n_sof - s0, 1);
        check("t6_final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
